// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Used by rr_arbiter and rf_wb_arbiter (optional forwarding macro: RF_WB_FWD_EN).
package rf_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester found scanning from
// i_ptr upward (mod N_REQ) wins; the grant vector is one-hot or zero.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PW-1:0]    o_grant_idx,
  output logic             o_grant_valid
);

  int w_best_dist;
  int w_dist;

  // Distance from the pointer in scan order; the smallest distance wins.
  always_comb begin
    w_best_dist   = N_REQ;
    w_dist        = 0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    o_grant       = '0;
    for (int j = 0; j < N_REQ; j++) begin
      w_dist = (j + N_REQ - int'(i_ptr)) % N_REQ;
      if (i_req[j] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        o_grant_idx = PW'(j);
      end
    end
    o_grant_valid = (w_best_dist < N_REQ);
    for (int j = 0; j < N_REQ; j++) begin
      o_grant[j] = o_grant_valid && (o_grant_idx == PW'(j));
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter for the register file's single write port,
// with a registered write stage and a saturating conflict counter.
// Optional in-flight write forwarding is enabled with macro RF_WB_FWD_EN.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int XLEN   = rf_pkg::XLEN,
  parameter int REG_AW = rf_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_hold,
  input  logic [N_REQ-1:0]        i_req_valid,
  output logic [N_REQ-1:0]        o_req_ready,
  input  logic [N_REQ*REG_AW-1:0] i_req_rd_addr,
  input  logic [N_REQ*XLEN-1:0]   i_req_data,
  output logic                    o_we,
  output logic [REG_AW-1:0]       o_rd_addr,
  output logic [XLEN-1:0]         o_rd_data,
  output logic [CNT_W-1:0]        o_conflict_cnt
`ifdef RF_WB_FWD_EN
  ,
  input  logic [REG_AW-1:0]       i_fwd_rs1_addr,
  input  logic [REG_AW-1:0]       i_fwd_rs2_addr,
  output logic                    o_fwd_rs1_hit,
  output logic                    o_fwd_rs2_hit,
  output logic [XLEN-1:0]         o_fwd_data
`endif
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]     r_rr_ptr;
  logic              r_we;
  logic [REG_AW-1:0] r_rd_addr;
  logic [XLEN-1:0]   r_rd_data;
  logic [CNT_W-1:0]  r_conflict_cnt;

  logic [N_REQ-1:0]  w_req_masked;
  logic [N_REQ-1:0]  w_grant;
  logic [PW-1:0]     w_grant_idx;
  logic              w_grant_valid;
  logic [PW-1:0]     w_next_ptr;
  logic [REG_AW-1:0] w_sel_addr;
  logic [XLEN-1:0]   w_sel_data;
  logic              w_contend;

  // hold freezes the pipeline: no request is visible to the arbiter.
  assign w_req_masked = i_hold ? '0 : i_req_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_arbiter (
    .i_req         (w_req_masked),
    .i_ptr         (r_rr_ptr),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  assign o_req_ready = w_grant;

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_grant[j]) begin
        w_sel_addr = i_req_rd_addr[j*REG_AW +: REG_AW];
        w_sel_data = i_req_data[j*XLEN +: XLEN];
      end
    end
  end

  assign w_next_ptr = (w_grant_idx == PW'(N_REQ - 1)) ? '0 : w_grant_idx + PW'(1);
  assign w_contend  = !i_hold && ($countones(i_req_valid) >= 2);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr  <= '0;
      r_we      <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else if (w_grant_valid) begin
      r_rr_ptr  <= w_next_ptr;
      // x0 writes complete the handshake but never reach the register file.
      r_we      <= (w_sel_addr != REG_AW'(ZERO_REG));
      r_rd_addr <= w_sel_addr;
      r_rd_data <= w_sel_data;
    end else begin
      r_we      <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_conflict_cnt <= '0;
    end else if (w_contend && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign o_we           = r_we;
  assign o_rd_addr      = r_rd_addr;
  assign o_rd_data      = r_rd_data;
  assign o_conflict_cnt = r_conflict_cnt;

`ifdef RF_WB_FWD_EN
  assign o_fwd_rs1_hit = r_we && (r_rd_addr == i_fwd_rs1_addr) &&
                         (i_fwd_rs1_addr != REG_AW'(ZERO_REG));
  assign o_fwd_rs2_hit = r_we && (r_rd_addr == i_fwd_rs2_addr) &&
                         (i_fwd_rs2_addr != REG_AW'(ZERO_REG));
  assign o_fwd_data    = r_rd_data;
`endif

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port among N_REQ writeback requesters, such as the ALU/WB stage, the load unit and a multi-cycle mul/div unit. Uses round-robin arbitration with a valid/ready handshake per requester. One registered output stage drives the reg_file write port (we, rd_addr, rd_data). Counts write-port conflict cycles. Optionally forwards the in-flight write to the read ports.

Parameters:
N_REQ, 2, number of requesters; legal range 2..4.
XLEN, 32, data width.
REG_AW, 5, register address width.
CNT_W, 16, conflict counter width.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
hold  in  1  suppresses all grants this cycle (pipeline freeze).
req_valid  in  N_REQ  per-requester write request.
req_ready  out  N_REQ  per-requester grant; one-hot or zero; combinational.
req_rd_addr  in  N_REQ*REG_AW  packed destination addresses; requester i at bits [i*REG_AW +: REG_AW].
req_data  in  N_REQ*XLEN  packed write data; requester i at bits [i*XLEN +: XLEN].
we  out  1  to reg_file.we; registered.
rd_addr  out  REG_AW  to reg_file.rd_addr; registered.
rd_data  out  XLEN  to reg_file.rd_data; registered.
conflict_cnt  out  CNT_W  saturating count of contention cycles.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: we=0, rd_addr=0, rd_data=0, rr_ptr=0, conflict_cnt=0.
- Reset mid-operation: a registered write not yet committed is discarded. No write occurs at the next edge.
- Transfer rule: a transfer on requester i happens when req_valid[i] && req_ready[i] at a posedge.
- Requester contract: a requester keeps valid, addr and data stable until it is accepted. req_valid must not depend on req_ready.
- req_ready[i] is asserted only if all of the following hold:
  - hold=0;
  - req_valid[i]=1;
  - i is the first valid index scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
- req_ready is all-zero when hold=1 or when no request is valid.
- Round-robin pointer: after a grant to i, rr_ptr <= (i+1) mod N_REQ. rr_ptr is unchanged when there is no grant.
- Output stage: on a grant at edge k, the registered stage loads we=(addr!=0), rd_addr=addr, rd_data=data. reg_file commits at edge k+1, so grant-to-architectural-state latency is 2 edges.
- No grant at edge k: we<=0 at edge k. rd_addr and rd_data hold their previous values.
- x0 writes: accepted normally (handshake completes and the rr pointer advances), but we stays 0. x0 is never driven as a write target.
- Back-to-back: one grant per cycle sustains one write per cycle.
- Same address from two requesters in consecutive cycles: both commit in grant order, so the last writer wins.
- conflict_cnt increments when hold=0 and popcount(req_valid)>=2, saturating at all-ones.
- hold=1 with valids pending: no grants, rr_ptr frozen, conflict_cnt frozen, we<=0 at that edge.

Optional Feature:
Macro RF_WB_FWD_EN.
- With the macro defined:
  - Extra ports: fwd_rs1_addr and fwd_rs2_addr (in, REG_AW each); fwd_rs1_hit and fwd_rs2_hit (out, 1 each); fwd_data (out, XLEN).
  - fwd_rsN_hit = we && rd_addr==fwd_rsN_addr && fwd_rsN_addr!=0. This is combinational from the registered stage.
  - fwd_data = rd_data.
  - Purpose: the consumer muxes the in-flight write over reg_file's combinational read.
- Without the macro: none of these ports or logic exist.

Decomposition:
- Package rf_pkg:
  - XLEN and REG_AW constants;
  - typedef reg_addr_t (REG_AW bits);
  - typedef xlen_t (XLEN bits);
  - constant ZERO_REG = 0.
- Sub-module rr_arbiter, purely combinational: inputs req mask and ptr; outputs one-hot grant and grant index.
- rf_wb_arbiter owns rr_ptr, the output stage, conflict_cnt and the optional forwarding.

Test Plan:
1. Reset then idle -> we=0, req_ready=0, conflict_cnt=0. Assert rst mid-cycle with a granted write pending -> we drops to 0 immediately, and reg_file x-reg is unchanged.
2. Only req0 valid with addr=5, data=123 -> req_ready=01 that cycle, we=1/rd_addr=5/rd_data=123 the next cycle, and reg_file x5 reads 123 after the following edge.
3. N_REQ=2, both valid every cycle (req0 addr=10 data=456; req1 addr=11 data=789) for 4 cycles -> grants alternate 0,1,0,1 and conflict_cnt=4.
4. req1 valid with addr=0, data=999 -> handshake completes and rr_ptr advances, but we stays 0 and x0 reads 0.
5. hold=1 for 3 cycles with both valid -> req_ready=00, we=0, conflict_cnt unchanged. After hold drops, the grant goes to the index stored in rr_ptr.
6. With RF_WB_FWD_EN defined: req0 addr=7 data=0xDEAD granted, fwd_rs1_addr=7, fwd_rs2_addr=0 -> in the cycle we=1, fwd_rs1_hit=1, fwd_data=0xDEAD, fwd_rs2_hit=0.
